// File: rtl/spatz_pkg.sv
// -----------------------------------------------------------------------------
// spatz_pkg
// Shared types and constants for the Spatz vector register file and its
// write-port arbitration.
//   vreg_addr_t            : VRF word address
//   vreg_data_t            : VRF write data word
//   vreg_be_t              : per-byte write enables for one data word
//   NrVrfWriteRequesters   : units sharing one VRF write port (VFU, VLSU, slide)
//   wport_state_e          : state of the write-port arbiter output stage
// -----------------------------------------------------------------------------
package spatz_pkg;

  localparam int unsigned VregAddrWidth = 5;
  localparam int unsigned VregDataWidth = 32;
  localparam int unsigned VregBeWidth   = VregDataWidth / 8;

  typedef logic [VregAddrWidth-1:0] vreg_addr_t;
  typedef logic [VregDataWidth-1:0] vreg_data_t;
  typedef logic [VregBeWidth-1:0]   vreg_be_t;

  localparam int unsigned NrVrfWriteRequesters = 3;

  // IDLE: output stage empty. BUSY: one granted beat waits for the VRF.
  typedef enum logic {
    WP_IDLE = 1'b0,
    WP_BUSY = 1'b1
  } wport_state_e;

endpackage

// File: rtl/spatz_rr_pick.sv
// -----------------------------------------------------------------------------
// spatz_rr_pick
// Combinational round-robin selector: returns the first set request bit at or
// above the pointer, wrapping around to index 0.
//   req_i   : request vector, one bit per requester
//   ptr_i   : round-robin start index (always < NrRequesters)
//   idx_o   : winning index (0 when nothing is requested)
//   valid_o : at least one request bit is set
// -----------------------------------------------------------------------------
module spatz_rr_pick #(
  parameter  int unsigned NrRequesters = 3,
  localparam int unsigned IdxW         = $clog2(NrRequesters)
) (
  input  logic [NrRequesters-1:0] req_i,
  input  logic [IdxW-1:0]         ptr_i,
  output logic [IdxW-1:0]         idx_o,
  output logic                    valid_o
);

  // Walk the requesters starting at the pointer and stop on the first hit;
  // the valid flag doubles as the "already found" marker.
  always_comb begin : pick
    int unsigned cand;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int unsigned off = 0; off < NrRequesters; off++) begin
      cand = (32'(ptr_i) + off) % NrRequesters;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/spatz_vrf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// spatz_vrf_wport_arbiter
// Shares one VRF write port between several write requesters. Round-robin
// arbitration with an optional burst lock and a starvation limit on the lock.
// The winning beat is registered, so the VRF sees it one cycle later.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   req_waddr_i    : per-requester write address
//   req_wdata_i    : per-requester write data
//   req_wbe_i      : per-requester byte enables
//   req_we_i       : per-requester write request, held until req_wvalid_o
//   req_lock_i     : owner wants to keep the port after its current beat
//   req_wvalid_o   : one-hot write-accepted pulse back to the owner
//   vrf_waddr_o, vrf_wdata_o, vrf_wbe_o, vrf_we_o : registered VRF write beat
//   vrf_wvalid_i   : VRF accepted the beat
//   owner_o        : index of the requester held in the output stage
// -----------------------------------------------------------------------------
module spatz_vrf_wport_arbiter
  import spatz_pkg::*;
#(
  parameter  int unsigned NrRequesters = NrVrfWriteRequesters,
  parameter  int unsigned MaxLockBeats = 8,
  localparam int unsigned IdxW         = $clog2(NrRequesters)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  vreg_addr_t [NrRequesters-1:0]       req_waddr_i,
  input  vreg_data_t [NrRequesters-1:0]       req_wdata_i,
  input  vreg_be_t   [NrRequesters-1:0]       req_wbe_i,
  input  logic       [NrRequesters-1:0]       req_we_i,
  input  logic       [NrRequesters-1:0]       req_lock_i,
  output logic       [NrRequesters-1:0]       req_wvalid_o,
  output vreg_addr_t                          vrf_waddr_o,
  output vreg_data_t                          vrf_wdata_o,
  output vreg_be_t                            vrf_wbe_o,
  output logic                                vrf_we_o,
  input  logic                                vrf_wvalid_i,
  output logic       [IdxW-1:0]               owner_o
);

  localparam int unsigned CntW = $clog2(MaxLockBeats + 1);

  wport_state_e     state_q, state_d;
  vreg_addr_t       waddr_q, waddr_d;
  vreg_data_t       wdata_q, wdata_d;
  vreg_be_t         wbe_q,   wbe_d;
  logic [IdxW-1:0]  owner_q, owner_d;
  logic [IdxW-1:0]  rr_q,    rr_d;
  logic             lock_q,  lock_d;
  logic [CntW-1:0]  cnt_q,   cnt_d;

  logic                    ack;
  logic                    arb;
  logic [NrRequesters-1:0] owner_oh;
  logic [NrRequesters-1:0] elig;
  logic [NrRequesters-1:0] others;
  logic                    lock_limit;
  logic                    lock_cand;
  logic                    lock_win;
  logic                    lock_hold;
  logic                    win;
  logic [IdxW-1:0]         win_idx;
  logic [IdxW-1:0]         rr_idx;
  logic                    rr_valid;

  // Decode the arbitration context. The acknowledged owner's request is stale
  // in its ack cycle, so it is removed from the eligible set there. The ack is
  // suppressed during reset so a dropped beat never reports acceptance.
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    ack        = (state_q == WP_BUSY) && vrf_wvalid_i && !rst_i;
    arb        = (state_q == WP_IDLE) || ack;
    elig       = req_we_i & (ack ? ~owner_oh : {NrRequesters{1'b1}});
    others     = elig & ~owner_oh;
    lock_limit = (cnt_q == CntW'(MaxLockBeats));
    // In IDLE the latched lock of the previous owner decides the win directly.
    lock_cand  = (state_q == WP_IDLE) && lock_q && req_we_i[owner_q];
    lock_win   = lock_cand && !lock_limit;
    // At ack the owner cannot win yet (its request is stale), so a fresh lock
    // request keeps the port free for one cycle instead of handing it over;
    // the owner then takes it back from IDLE. This is why a locked owner gets
    // one beat every two cycles.
    lock_hold  = ack && req_lock_i[owner_q] && !lock_limit;
    win        = arb && (lock_win || (!lock_hold && rr_valid));
    win_idx    = lock_win ? owner_q : rr_idx;
  end

  spatz_rr_pick #(
    .NrRequesters(NrRequesters)
  ) i_rr_pick (
    .req_i  (elig),
    .ptr_i  (rr_q),
    .idx_o  (rr_idx),
    .valid_o(rr_valid)
  );

  // Next-state logic for the output stage, round-robin pointer, lock latch and
  // lock counter. Nothing moves while a beat waits for the VRF.
  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wbe_d   = wbe_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    cnt_d   = cnt_q;

    if (arb) begin
      if (win) begin
        state_d = WP_BUSY;
        waddr_d = req_waddr_i[win_idx];
        wdata_d = req_wdata_i[win_idx];
        wbe_d   = req_wbe_i[win_idx];
        owner_d = win_idx;
      end else begin
        state_d = WP_IDLE;
      end

      if (win && !lock_win) begin
        rr_d = (win_idx == IdxW'(NrRequesters - 1)) ? '0 : win_idx + 1'b1;
      end

      // Count lock wins only while someone else is waiting; once the limit is
      // reached the lock is ignored for one arbitration and the count restarts.
      if (lock_win) begin
        if (|others) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (win || lock_limit) begin
        cnt_d = '0;
      end

      // The lock is re-sampled at every ack; an IDLE arbitration consumes it,
      // and a silent owner loses it.
      if (ack) begin
        lock_d = req_lock_i[owner_q];
      end else begin
        lock_d = 1'b0;
      end
    end
  end

  // All state registers with synchronous reset; a pending beat is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WP_IDLE;
      waddr_q <= '0;
      wdata_q <= '0;
      wbe_q   <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wbe_q   <= wbe_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vrf_we_o     = (state_q == WP_BUSY);
  assign vrf_waddr_o  = waddr_q;
  assign vrf_wdata_o  = wdata_q;
  assign vrf_wbe_o    = wbe_q;
  assign owner_o      = owner_q;
  assign req_wvalid_o = ack ? owner_oh : '0;

  // Protocol checks on the requester and VRF interfaces.
  for (genvar i = 0; i < NrRequesters; i++) begin : g_we_hold
    assert property (@(posedge clk_i) disable iff (rst_i)
      (req_we_i[i] && !req_wvalid_o[i]) |=> req_we_i[i]);
  end

  assert property (@(posedge clk_i) $onehot0(req_wvalid_o));

  assert property (@(posedge clk_i) disable iff (rst_i)
    (vrf_we_o && !vrf_wvalid_i) |=>
      ($stable(vrf_waddr_o) && $stable(vrf_wdata_o) &&
       $stable(vrf_wbe_o) && $stable(vrf_we_o) && $stable(owner_o)));

endmodule

// File: tb/tb_spatz_vrf_wport_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spatz_vrf_wport_arbiter
// Directed bench for the VRF write-port arbiter: reset values, single beat,
// round-robin contention, VRF backpressure, lock starvation limit and reset in
// the middle of a beat. Requester i drives address 10+i, data A0000000+i and
// byte enable 1<<i unless a test overrides it.
// -----------------------------------------------------------------------------
module tb_spatz_vrf_wport_arbiter;
  import spatz_pkg::*;

  localparam int unsigned NrReq   = NrVrfWriteRequesters;
  localparam int unsigned MaxLock = 2;

  logic                     clk;
  logic                     rst;
  vreg_addr_t [NrReq-1:0]   reqWaddr;
  vreg_data_t [NrReq-1:0]   reqWdata;
  vreg_be_t   [NrReq-1:0]   reqWbe;
  logic       [NrReq-1:0]   reqWe;
  logic       [NrReq-1:0]   reqLock;
  logic       [NrReq-1:0]   reqWvalid;
  vreg_addr_t               vrfWaddr;
  vreg_data_t               vrfWdata;
  vreg_be_t                 vrfWbe;
  logic                     vrfWe;
  logic                     vrfWvalid;
  logic       [1:0]         owner;

  int testsRun;
  int testsFailed;

  spatz_vrf_wport_arbiter #(
    .NrRequesters(NrReq),
    .MaxLockBeats(MaxLock)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_waddr_i (reqWaddr),
    .req_wdata_i (reqWdata),
    .req_wbe_i   (reqWbe),
    .req_we_i    (reqWe),
    .req_lock_i  (reqLock),
    .req_wvalid_o(reqWvalid),
    .vrf_waddr_o (vrfWaddr),
    .vrf_wdata_o (vrfWdata),
    .vrf_wbe_o   (vrfWbe),
    .vrf_we_o    (vrfWe),
    .vrf_wvalid_i(vrfWvalid),
    .owner_o     (owner)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive the per-cycle request controls, then let combinational paths settle.
  task automatic applyStimulus(input logic [2:0] we, input logic [2:0] lock,
                               input logic wvalid);
    reqWe     = we;
    reqLock   = lock;
    vrfWvalid = wvalid;
    #2;
  endtask

  // The single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // A beat from requester expOwner sits in the output stage.
  task automatic checkBeat(input string tag, input int expOwner,
                           input logic [2:0] expWvalid);
    checkOutput({tag, ".we"},     32'(vrfWe),     32'd1);
    checkOutput({tag, ".owner"},  32'(owner),     32'(expOwner));
    checkOutput({tag, ".waddr"},  32'(vrfWaddr),  32'd10 + 32'(expOwner));
    checkOutput({tag, ".wdata"},  32'(vrfWdata),  32'hA000_0000 + 32'(expOwner));
    checkOutput({tag, ".wbe"},    32'(vrfWbe),    32'd1 << expOwner);
    checkOutput({tag, ".wvalid"}, 32'(reqWvalid), 32'(expWvalid));
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".we"},     32'(vrfWe),     32'd0);
    checkOutput({tag, ".wvalid"}, 32'(reqWvalid), 32'd0);
  endtask

  // Two reset cycles: requests stay up for the first one so no requester is
  // seen dropping a request outside reset, then everything is cleared.
  task automatic doReset();
    rst = 1'b1;
    nextCycle();
    applyStimulus(3'b000, 3'b000, 1'b0);
    nextCycle();
    rst = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    logic [2:0] lockBusy [7];
    int         lockOwner[7];

    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    reqWe       = '0;
    reqLock     = '0;
    vrfWvalid   = 1'b0;
    for (int i = 0; i < int'(NrReq); i++) begin
      reqWaddr[i] = vreg_addr_t'(10 + i);
      reqWdata[i] = 32'hA000_0000 + 32'(i);
      reqWbe[i]   = vreg_be_t'(1 << i);
    end

    // Reset values, with the VRF acking so a stray pulse would show.
    doReset();
    applyStimulus(3'b000, 3'b000, 1'b1);
    checkOutput("rst.we",     32'(vrfWe),     32'd0);
    checkOutput("rst.waddr",  32'(vrfWaddr),  32'd0);
    checkOutput("rst.wdata",  32'(vrfWdata),  32'd0);
    checkOutput("rst.wbe",    32'(vrfWbe),    32'd0);
    checkOutput("rst.owner",  32'(owner),     32'd0);
    checkOutput("rst.wvalid", 32'(reqWvalid), 32'd0);

    // Single request, VRF always ready: beat visible one cycle later, then idle.
    reqWaddr[0] = vreg_addr_t'(5);
    applyStimulus(3'b001, 3'b000, 1'b1);
    checkIdle("single.c0");
    nextCycle();
    applyStimulus(3'b001, 3'b000, 1'b1);
    checkOutput("single.c1.we",     32'(vrfWe),     32'd1);
    checkOutput("single.c1.waddr",  32'(vrfWaddr),  32'd5);
    checkOutput("single.c1.wdata",  32'(vrfWdata),  32'hA000_0000);
    checkOutput("single.c1.wvalid", 32'(reqWvalid), 32'b001);
    nextCycle();
    applyStimulus(3'b000, 3'b000, 1'b1);
    checkIdle("single.c2");
    reqWaddr[0] = vreg_addr_t'(10);

    // Full contention from reset: grants rotate 0,1,2,... with no bubble.
    doReset();
    applyStimulus(3'b111, 3'b000, 1'b1);
    checkIdle("cont.c0");
    for (int k = 1; k <= 6; k++) begin
      nextCycle();
      applyStimulus(3'b111, 3'b000, 1'b1);
      checkBeat($sformatf("cont.c%0d", k), (k - 1) % 3, 3'(1 << ((k - 1) % 3)));
    end
    doReset();

    // Backpressure: requester 1 waits four cycles, then gets a single ack.
    applyStimulus(3'b010, 3'b000, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      nextCycle();
      applyStimulus(3'b010, 3'b000, 1'b0);
      checkBeat($sformatf("bp.c%0d", k), 1, 3'b000);
    end
    nextCycle();
    applyStimulus(3'b010, 3'b000, 1'b1);
    checkBeat("bp.c5", 1, 3'b010);
    nextCycle();
    applyStimulus(3'b000, 3'b000, 1'b0);
    checkIdle("bp.c6");
    doReset();

    // Lock starvation with MaxLockBeats=2: requester 0 takes its first beat by
    // round-robin, then two lock wins (each followed by a held idle cycle), and
    // then requester 2 gets the port before requester 0 returns.
    lockBusy  = '{3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1};
    lockOwner = '{0, 0, 0, 0, 0, 2, 0};
    applyStimulus(3'b101, 3'b001, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      nextCycle();
      applyStimulus(3'b101, 3'b001, 1'b1);
      if (lockBusy[k-1][0]) begin
        checkBeat($sformatf("lock.c%0d", k), lockOwner[k-1],
                  3'(1 << lockOwner[k-1]));
      end else begin
        checkIdle($sformatf("lock.c%0d", k));
      end
    end
    doReset();

    // Reset while a beat waits: no ack, pointer back to 0, request re-served.
    applyStimulus(3'b010, 3'b000, 1'b0);
    nextCycle();
    applyStimulus(3'b010, 3'b000, 1'b0);
    checkBeat("rstmid.c1", 1, 3'b000);
    rst = 1'b1;
    applyStimulus(3'b010, 3'b000, 1'b1);
    checkOutput("rstmid.c1.noack", 32'(reqWvalid), 32'd0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(3'b110, 3'b000, 1'b1);
    checkIdle("rstmid.c2");
    checkOutput("rstmid.c2.owner", 32'(owner), 32'd0);
    nextCycle();
    applyStimulus(3'b110, 3'b000, 1'b1);
    checkBeat("rstmid.c3", 1, 3'b010);
    nextCycle();
    applyStimulus(3'b100, 3'b000, 1'b1);
    checkBeat("rstmid.c4", 2, 3'b100);
    nextCycle();
    applyStimulus(3'b000, 3'b000, 1'b1);
    checkIdle("rstmid.c5");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
